// File: rtl/systolic_feeder.sv
// systolic_feeder: operand staging buffers and diagonal skew feeder for an
// NxN systolic MAC array. A and B are loaded one element per cycle while idle;
// a start pulse streams 2N-1 skewed vectors, drains with zeros, then pulses done.
module systolic_feeder #(
   parameter int unsigned D_W   = 8,
   parameter int unsigned N     = 2,
   parameter int unsigned DRAIN = 2*N,
   localparam int unsigned AW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               wr_sel,
   input  logic [AW-1:0]      wr_row,
   input  logic [AW-1:0]      wr_col,
   input  logic [D_W-1:0]     wr_data,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               init,
   output logic [N*D_W-1:0]   x_flat,
   output logic [N*D_W-1:0]   y_flat
);

   localparam int unsigned LAST_STEP = 2*N - 2;
   localparam int unsigned TW        = $clog2(2*N + DRAIN + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN} state_t;

   state_t           state;
   logic [TW-1:0]    t;
   logic [D_W-1:0]   a_buf [N][N];
   logic [D_W-1:0]   b_buf [N][N];

   logic [TW-1:0]    nxt_step_c;
   logic [N*D_W-1:0] x_nxt_c;
   logic [N*D_W-1:0] y_nxt_c;
   logic             wr_ok_c;

   // Buffer writes only land when idle, not colliding with start, and in range.
   assign wr_ok_c = wr_en && !start && (32'(wr_row) < N) && (32'(wr_col) < N);

   // Skewed vector for the step about to be registered: lane i takes the
   // element whose row+column index sum equals the step.
   always_comb begin
      nxt_step_c = (state == ST_IDLE) ? '0 : t + TW'(1);
      x_nxt_c    = '0;
      y_nxt_c    = '0;
      for (int i = 0; i < int'(N); i++) begin
         for (int k = 0; k < int'(N); k++) begin
            if (i + k == int'(nxt_step_c)) begin
               x_nxt_c[i*D_W +: D_W] = a_buf[i][k];
               y_nxt_c[i*D_W +: D_W] = b_buf[k][i];
            end
         end
      end
   end

   // Sequencer, registered outputs and operand buffers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         t      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         init   <= 1'b0;
         x_flat <= '0;
         y_flat <= '0;
         for (int i = 0; i < int'(N); i++) begin
            for (int k = 0; k < int'(N); k++) begin
               a_buf[i][k] <= '0;
               b_buf[i][k] <= '0;
            end
         end
      end else begin
         done <= 1'b0;
         init <= 1'b0;
         case (state)
            ST_IDLE: begin
               x_flat <= '0;
               y_flat <= '0;
               if (start) begin
                  state  <= ST_FEED;
                  t      <= '0;
                  busy   <= 1'b1;
                  init   <= 1'b1;
                  x_flat <= x_nxt_c;
                  y_flat <= y_nxt_c;
               end else if (wr_ok_c) begin
                  if (wr_sel) b_buf[wr_row][wr_col] <= wr_data;
                  else        a_buf[wr_row][wr_col] <= wr_data;
               end
            end
            ST_FEED: begin
               if (32'(t) == LAST_STEP) begin
                  x_flat <= '0;
                  y_flat <= '0;
                  t      <= '0;
                  if (DRAIN == 0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else begin
                  t      <= t + TW'(1);
                  x_flat <= x_nxt_c;
                  y_flat <= y_nxt_c;
               end
            end
            ST_DRAIN: begin
               x_flat <= '0;
               y_flat <= '0;
               if (32'(t) == DRAIN - 1) begin
                  state <= ST_IDLE;
                  t     <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  t <= t + TW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=2, D_W=8, DRAIN=4).
module tb_systolic_feeder;

   localparam int unsigned D_W    = 8;
   localparam int unsigned N      = 2;
   localparam int unsigned DRAIN  = 4;
   localparam int unsigned AW     = 1;
   localparam int          PERIOD = 2*N - 1 + DRAIN + 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               wr_en = 1'b0;
   logic               wr_sel = 1'b0;
   logic [AW-1:0]      wr_row = '0;
   logic [AW-1:0]      wr_col = '0;
   logic [D_W-1:0]     wr_data = '0;
   logic               start = 1'b0;
   logic               busy, done, init;
   logic [N*D_W-1:0]   x_flat, y_flat;

   systolic_feeder #(.D_W(D_W), .N(N), .DRAIN(DRAIN)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
      .busy(busy), .done(done), .init(init), .x_flat(x_flat), .y_flat(y_flat)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic        init;
      logic        busy;
      logic        done;
   } obs_t;

   // a/b index = row*2+col; ex/ey index = vector step
   typedef struct packed {
      logic [3:0][7:0]  a;
      logic [3:0][7:0]  b;
      logic [2:0][15:0] ex;
      logic [2:0][15:0] ey;
   } tc_t;

   obs_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   tc_t  tc [3];

   // Expected observation p cycles after the start edge (p=0 is vector 0).
   function automatic obs_t exp_at(input int p, input logic [2:0][15:0] ex,
                                   input logic [2:0][15:0] ey);
      obs_t o;
      o = '0;
      if (p <= 2) begin
         o.x    = ex[p];
         o.y    = ey[p];
         o.busy = 1'b1;
         o.init = (p == 0);
      end else if (p < PERIOD - 1) begin
         o.busy = 1'b1;
      end else begin
         o.done = 1'b1;
      end
      return o;
   endfunction

   task automatic check(input string nm);
      obs_t act, e;
      act.x = x_flat; act.y = y_flat;
      act.init = init; act.busy = busy; act.done = done;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got x=%h y=%h", nm, act.x, act.y);
      end else begin
         e = sb.pop_front();
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got x=%h y=%h init=%b busy=%b done=%b, required x=%h y=%h init=%b busy=%b done=%b",
                     nm, act.x, act.y, act.init, act.busy, act.done,
                     e.x, e.y, e.init, e.busy, e.done);
         end
      end
   endtask

   task automatic wr(input logic sel, input int r, input int c, input logic [7:0] d);
      wr_en = 1'b1; wr_sel = sel; wr_row = AW'(r); wr_col = AW'(c); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic load(input tc_t tv);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            wr(1'b0, r, c, tv.a[r*2+c]);
            wr(1'b1, r, c, tv.b[r*2+c]);
         end
   endtask

   // mode 0: plain run; 1: write and start attempts while busy; 2: start+wr_en collision
   task automatic run(input string nm, input logic [2:0][15:0] ex,
                      input logic [2:0][15:0] ey, input int mode);
      for (int p = 0; p < PERIOD; p++) sb.push_back(exp_at(p, ex, ey));
      sb.push_back('0);
      start = 1'b1;
      if (mode == 2) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'h55;
      end
      for (int k = 0; k <= PERIOD; k++) begin
         @(negedge clk);
         start = 1'b0;
         wr_en = 1'b0;
         if (mode == 1 && k == 0) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'hFF;
         end
         if (mode == 1 && k == 4) start = 1'b1;
         check(nm);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      tc[0].a  = {8'd4, 8'd3, 8'd2, 8'd1};
      tc[0].b  = {8'd8, 8'd7, 8'd6, 8'd5};
      tc[0].ex = {16'h0400, 16'h0302, 16'h0001};
      tc[0].ey = {16'h0800, 16'h0607, 16'h0005};
      tc[1].a  = {8'h44, 8'h33, 8'h22, 8'h11};
      tc[1].b  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      tc[1].ex = {16'h4400, 16'h3322, 16'h0011};
      tc[1].ey = {16'hDD00, 16'hBBCC, 16'h00AA};
      tc[2].a  = {8'h80, 8'h00, 8'h00, 8'hFF};
      tc[2].b  = {8'h00, 8'hFE, 8'h01, 8'h00};
      tc[2].ex = {16'h8000, 16'h0000, 16'h00FF};
      tc[2].ey = {16'h0000, 16'h01FE, 16'h0000};

      // reset with random stimulus
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wr_en = 1'($urandom); start = 1'($urandom); wr_sel = 1'($urandom);
         wr_row = AW'($urandom); wr_col = AW'($urandom); wr_data = 8'($urandom);
         @(negedge clk);
         sb.push_back('0);
         check("reset");
      end
      wr_en = 1'b0; start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      run("zero_after_reset", '0, '0, 0);

      // table-driven skew patterns
      for (int i = 0; i < 3; i++) begin
         load(tc[i]);
         run($sformatf("skew_vec%0d", i), tc[i].ex, tc[i].ey, 0);
      end

      // writes and start ignored while busy
      load(tc[0]);
      run("busy_write", tc[0].ex, tc[0].ey, 1);
      run("busy_rerun", tc[0].ex, tc[0].ey, 0);

      // start has priority over a same-cycle write
      run("collide", tc[0].ex, tc[0].ey, 2);
      run("collide_rerun", tc[0].ex, tc[0].ey, 0);

      // asynchronous reset at vector 1
      sb.push_back(exp_at(0, tc[0].ex, tc[0].ey));
      sb.push_back(exp_at(1, tc[0].ex, tc[0].ey));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("mid_v0");
      @(negedge clk);
      check("mid_v1");
      rst = 1'b0;
      #1;
      sb.push_back('0);
      check("mid_async");
      @(negedge clk);
      sb.push_back('0);
      check("mid_hold");
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         sb.push_back('0);
         check("mid_no_done");
      end
      run("mid_cleared", '0, '0, 0);

      // start held high for 20 cycles
      load(tc[1]);
      start = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k == 20) start = 1'b0;
         if (k <= 24) sb.push_back(exp_at((k - 1) % PERIOD, tc[1].ex, tc[1].ey));
         else         sb.push_back('0);
         check("back_to_back");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
